// File: rtl/lapido_ctrl_pipeline.sv
// Pipelined control unit for the LAMBA core: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use hazard detection, EX forwarding selects, flush and freeze handling.
module lapido_ctrl_pipeline #(
    parameter int unsigned REG_ADDR_W         = 4,
    parameter int unsigned LINK_REG           = 15,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1,
    parameter bit          HAZARD_EN          = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ext_stall,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  id_is_jump,
    output logic                  id_sel_j_jr,
    output logic [5:0]            ex_alu_funct,
    output logic                  ex_alu_src,
    output logic                  ex_is_load,
    output logic                  ex_fl_we,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_we,
    output logic                  mem_is_branch,
    output logic                  mem_sel_beq_bne,
    output logic                  mem_sel_jt_jf,
    output logic                  mem_sel_jflag_branch,
    output logic [1:0]            wb_res_mux,
    output logic                  wb_reg_we,
    output logic [REG_ADDR_W-1:0] wb_dst
);

    // Encodings shared with the datapath (lapido_defs)
    localparam logic [5:0] OP_RTYPE   = 6'd0;
    localparam logic [5:0] OP_ADDI    = 6'd1;
    localparam logic [5:0] OP_ANDI    = 6'd2;
    localparam logic [5:0] OP_ORI     = 6'd3;
    localparam logic [5:0] OP_SLTI    = 6'd4;
    localparam logic [5:0] OP_LCL     = 6'd5;
    localparam logic [5:0] OP_LCH     = 6'd6;
    localparam logic [5:0] OP_LOAD    = 6'd7;
    localparam logic [5:0] OP_STORE   = 6'd8;
    localparam logic [5:0] OP_LOADLIT = 6'd9;
    localparam logic [5:0] OP_BEQ     = 6'd10;
    localparam logic [5:0] OP_BNE     = 6'd11;
    localparam logic [5:0] OP_JT      = 6'd12;
    localparam logic [5:0] OP_JF      = 6'd13;
    localparam logic [5:0] OP_J       = 6'd14;
    localparam logic [5:0] OP_JAL     = 6'd15;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic       ALU_SRC_REG = 1'b0;
    localparam logic       ALU_SRC_IMM = 1'b1;
    localparam logic       SEL_J       = 1'b0;
    localparam logic       SEL_JR      = 1'b1;
    localparam logic       SEL_BRANCH  = 1'b0;
    localparam logic       SEL_JFLAG   = 1'b1;
    localparam logic       SEL_BEQ     = 1'b0;
    localparam logic       SEL_BNE     = 1'b1;
    localparam logic       SEL_JT      = 1'b0;
    localparam logic       SEL_JF      = 1'b1;
    localparam logic [1:0] WB_ALU      = 2'd0;
    localparam logic [1:0] WB_MEM      = 2'd1;
    localparam logic [1:0] WB_PC       = 2'd2;
    localparam logic [1:0] WB_IMM      = 2'd3;

    localparam logic [REG_ADDR_W-1:0] LINK_DST = REG_ADDR_W'(LINK_REG);

    // Each stage register keeps only the fields still consumed downstream.
    typedef struct packed {
        logic                  reg_we;
        logic [1:0]            res_mux;
        logic [REG_ADDR_W-1:0] dst;
    } wb_ctl_t;

    typedef struct packed {
        logic    mem_we;
        logic    is_load;
        logic    is_branch;
        logic    sel_beq_bne;
        logic    sel_jt_jf;
        logic    sel_jflag_branch;
        wb_ctl_t wb;
    } mem_ctl_t;

    typedef struct packed {
        logic [5:0]            alu_funct;
        logic                  alu_src;
        logic                  fl_we;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        mem_ctl_t              mem;
    } ex_ctl_t;

    ex_ctl_t  id_ctl;
    logic     id_jump;
    logic     id_sel;
    ex_ctl_t  id_ex_q;
    mem_ctl_t ex_mem_q;
    wb_ctl_t  mem_wb_q;

    // Decode; everything not set for an instruction keeps its bubble value.
    always_comb begin
        id_ctl  = '0;
        id_jump = 1'b0;
        id_sel  = SEL_J;
        if (id_valid) begin
            id_ctl.rs = id_rs;
            id_ctl.rt = id_rt;
            case (id_opcode)
                OP_STORE: id_ctl.mem.mem_we = 1'b1;
                OP_LOAD: begin
                    id_ctl.mem.is_load    = 1'b1;
                    id_ctl.mem.wb.reg_we  = 1'b1;
                    id_ctl.mem.wb.res_mux = WB_MEM;
                    id_ctl.mem.wb.dst     = id_rt;
                end
                OP_J: begin
                    id_jump = 1'b1;
                    id_sel  = SEL_J;
                end
                OP_JAL: begin
                    id_jump               = 1'b1;
                    id_sel                = SEL_JR;
                    id_ctl.mem.wb.reg_we  = 1'b1;
                    id_ctl.mem.wb.res_mux = WB_PC;
                    id_ctl.mem.wb.dst     = LINK_DST;
                end
                OP_BEQ, OP_BNE: begin
                    id_ctl.mem.is_branch        = 1'b1;
                    id_ctl.alu_src              = ALU_SRC_REG;
                    id_ctl.alu_funct            = FN_SUB;
                    id_ctl.mem.sel_jflag_branch = SEL_BRANCH;
                    id_ctl.mem.sel_beq_bne      = (id_opcode == OP_BNE) ? SEL_BNE : SEL_BEQ;
                end
                OP_JT, OP_JF: begin
                    id_ctl.mem.is_branch        = 1'b1;
                    id_ctl.mem.sel_jflag_branch = SEL_JFLAG;
                    id_ctl.mem.sel_jt_jf        = (id_opcode == OP_JF) ? SEL_JF : SEL_JT;
                end
                OP_LOADLIT: begin
                    id_ctl.mem.wb.reg_we  = 1'b1;
                    id_ctl.mem.wb.res_mux = WB_IMM;
                    id_ctl.mem.wb.dst     = id_rt;
                end
                OP_RTYPE: begin
                    if (id_funct == FN_JR) begin
                        id_jump = 1'b1;
                        id_sel  = SEL_JR;
                    end else begin
                        id_ctl.alu_funct      = id_funct;
                        id_ctl.alu_src        = ALU_SRC_REG;
                        id_ctl.fl_we          = 1'b1;
                        id_ctl.mem.wb.reg_we  = 1'b1;
                        id_ctl.mem.wb.res_mux = WB_ALU;
                        id_ctl.mem.wb.dst     = id_rd;
                    end
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LCL, OP_LCH: begin
                    id_ctl.alu_src        = ALU_SRC_IMM;
                    id_ctl.fl_we          = 1'b1;
                    id_ctl.mem.wb.reg_we  = 1'b1;
                    id_ctl.mem.wb.res_mux = WB_ALU;
                    id_ctl.mem.wb.dst     = id_rt;
                    case (id_opcode)
                        OP_ADDI: id_ctl.alu_funct = FN_ADD;
                        OP_ANDI: id_ctl.alu_funct = FN_AND;
                        OP_ORI:  id_ctl.alu_funct = FN_OR;
                        OP_SLTI: id_ctl.alu_funct = FN_SLT;
                        OP_LCL:  id_ctl.alu_funct = OP_LCL;
                        default: id_ctl.alu_funct = OP_LCH;
                    endcase
                end
                default: id_ctl = '0;
            endcase
        end
    end

    logic ex_dst_ok;
    logic ld_use;

    assign ex_dst_ok    = !ZERO_REG_HARDWIRED || (id_ex_q.mem.wb.dst != '0);
    assign ld_use       = (id_ex_q.mem.wb.dst == id_rs) || (id_ex_q.mem.wb.dst == id_rt);
    assign hazard_stall = HAZARD_EN && id_valid && id_ex_q.mem.is_load && ex_dst_ok && ld_use
                          && !flush;

    assign id_is_jump  = id_jump && !flush && !hazard_stall;
    assign id_sel_j_jr = id_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else if (ext_stall) begin
            id_ex_q  <= id_ex_q;
            ex_mem_q <= ex_mem_q;
            mem_wb_q <= mem_wb_q;
        end else if (flush) begin
            // The resolving branch itself still retires.
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= ex_mem_q.wb;
        end else if (hazard_stall) begin
            id_ex_q  <= '0;
            ex_mem_q <= id_ex_q.mem;
            mem_wb_q <= ex_mem_q.wb;
        end else begin
            id_ex_q  <= id_ctl;
            ex_mem_q <= id_ex_q.mem;
            mem_wb_q <= ex_mem_q.wb;
        end
    end

    // Forwarding; a load result is not yet available in EX/MEM.
    logic rs_ok, rt_ok, mem_fwd_ok;
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    assign rs_ok      = !ZERO_REG_HARDWIRED || (id_ex_q.rs != '0);
    assign rt_ok      = !ZERO_REG_HARDWIRED || (id_ex_q.rt != '0);
    assign mem_fwd_ok = ex_mem_q.wb.reg_we && !ex_mem_q.is_load;
    assign mem_hit_a  = rs_ok && mem_fwd_ok && (ex_mem_q.wb.dst == id_ex_q.rs);
    assign mem_hit_b  = rt_ok && mem_fwd_ok && (ex_mem_q.wb.dst == id_ex_q.rt);
    assign wb_hit_a   = rs_ok && mem_wb_q.reg_we && (mem_wb_q.dst == id_ex_q.rs);
    assign wb_hit_b   = rt_ok && mem_wb_q.reg_we && (mem_wb_q.dst == id_ex_q.rt);

    always_comb begin
        fwd_a = 2'b00;
        if (mem_hit_a) begin
            fwd_a = 2'b01;
        end else if (wb_hit_a) begin
            fwd_a = 2'b10;
        end
        fwd_b = 2'b00;
        if (id_ex_q.alu_src != ALU_SRC_IMM) begin
            if (mem_hit_b) begin
                fwd_b = 2'b01;
            end else if (wb_hit_b) begin
                fwd_b = 2'b10;
            end
        end
    end

    assign ex_alu_funct         = id_ex_q.alu_funct;
    assign ex_alu_src           = id_ex_q.alu_src;
    assign ex_is_load           = id_ex_q.mem.is_load;
    assign ex_fl_we             = id_ex_q.fl_we;
    assign mem_we               = ex_mem_q.mem_we;
    assign mem_is_branch        = ex_mem_q.is_branch;
    assign mem_sel_beq_bne      = ex_mem_q.sel_beq_bne;
    assign mem_sel_jt_jf        = ex_mem_q.sel_jt_jf;
    assign mem_sel_jflag_branch = ex_mem_q.sel_jflag_branch;
    assign wb_res_mux           = mem_wb_q.res_mux;
    assign wb_reg_we            = mem_wb_q.reg_we;
    assign wb_dst               = mem_wb_q.dst;

endmodule

// File: tb/tb_lapido_ctrl_pipeline.sv
// Bench for lapido_ctrl_pipeline: directed scenarios then random instruction streams, all checked
// against an instruction-level pipeline model.
module tb_lapido_ctrl_pipeline;

    localparam int AW = 4;

    localparam logic [5:0] RTYPE = 6'd0,  ADDI = 6'd1,  ANDI = 6'd2,  ORI = 6'd3,  SLTI = 6'd4;
    localparam logic [5:0] LCL = 6'd5,    LCH = 6'd6,   LOAD = 6'd7,  STORE = 6'd8;
    localparam logic [5:0] LOADLIT = 6'd9, BEQ = 6'd10, BNE = 6'd11,  JT = 6'd12, JF = 6'd13;
    localparam logic [5:0] J = 6'd14,     JAL = 6'd15;
    localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_SLT = 6'h2a;

    logic          clk = 1'b0;
    logic          rst, id_valid, ext_stall, flush;
    logic [5:0]    id_opcode, id_funct;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          hazard_stall, id_is_jump, id_sel_j_jr;
    logic [5:0]    ex_alu_funct;
    logic          ex_alu_src, ex_is_load, ex_fl_we;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_we, mem_is_branch, mem_sel_beq_bne, mem_sel_jt_jf, mem_sel_jflag_branch;
    logic [1:0]    wb_res_mux;
    logic          wb_reg_we;
    logic [AW-1:0] wb_dst;

    always #5 clk = ~clk;

    lapido_ctrl_pipeline dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ext_stall(ext_stall), .flush(flush),
        .hazard_stall(hazard_stall), .id_is_jump(id_is_jump), .id_sel_j_jr(id_sel_j_jr),
        .ex_alu_funct(ex_alu_funct), .ex_alu_src(ex_alu_src), .ex_is_load(ex_is_load),
        .ex_fl_we(ex_fl_we), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_we(mem_we),
        .mem_is_branch(mem_is_branch), .mem_sel_beq_bne(mem_sel_beq_bne),
        .mem_sel_jt_jf(mem_sel_jt_jf), .mem_sel_jflag_branch(mem_sel_jflag_branch),
        .wb_res_mux(wb_res_mux), .wb_reg_we(wb_reg_we), .wb_dst(wb_dst)
    );

    // One in-flight instruction as the reference model sees it.
    typedef struct {
        int reg_we, is_load, mem_we, is_branch, fl_we, imm, beq_bne, jt_jf, jflag;
        int wb_mux, funct, dst, rs, rt, jump_kind;   // jump_kind: 0 none, 1 j, 2 register/link
    } instr_t;

    instr_t ex_m, mem_m, wb_m, bubble;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic instr_t decode(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                                      input int rs, input int rt, input int rd);
        instr_t d = '{default: 0};
        if (!v) return d;
        d.rs = rs;
        d.rt = rt;
        case (opc)
            STORE:     d.mem_we = 1;
            LOAD:      begin d.reg_we = 1; d.is_load = 1; d.wb_mux = 1; d.dst = rt; end
            J:         d.jump_kind = 1;
            JAL:       begin d.jump_kind = 2; d.reg_we = 1; d.wb_mux = 2; d.dst = 15; end
            BEQ, BNE:  begin d.is_branch = 1; d.funct = F_SUB; d.beq_bne = (opc == BNE); end
            JT, JF:    begin d.is_branch = 1; d.jflag = 1; d.jt_jf = (opc == JF); end
            LOADLIT:   begin d.reg_we = 1; d.wb_mux = 3; d.dst = rt; end
            RTYPE: begin
                if (fn == F_JR) d.jump_kind = 2;
                else begin d.funct = fn; d.dst = rd; d.reg_we = 1; d.fl_we = 1; end
            end
            ADDI, ANDI, ORI, SLTI, LCL, LCH: begin
                d.imm = 1; d.dst = rt; d.reg_we = 1; d.fl_we = 1;
                d.funct = (opc == ADDI) ? F_ADD : (opc == ANDI) ? F_AND : (opc == ORI) ? F_OR :
                          (opc == SLTI) ? F_SLT : opc;
            end
            default: d = '{default: 0};
        endcase
        return d;
    endfunction

    // Where an EX operand reading register src gets its value from.
    function automatic int src_of(input int src);
        if (src == 0) return 0;
        if (mem_m.reg_we == 1 && mem_m.is_load == 0 && mem_m.dst == src) return 1;
        if (wb_m.reg_we == 1 && wb_m.dst == src) return 2;
        return 0;
    endfunction

    // Present one cycle of inputs, check every output, then advance the model across the edge.
    task automatic step(input logic v, input logic [5:0] opc, input logic [5:0] fn, input int rs,
                        input int rt, input int rd, input logic st, input logic fl,
                        input logic r, output logic haz);
        instr_t d;
        @(negedge clk);
        id_valid = v; id_opcode = opc; id_funct = fn;
        id_rs = AW'(rs); id_rt = AW'(rt); id_rd = AW'(rd);
        ext_stall = st; flush = fl; rst = r;
        #1;
        d   = decode(v, opc, fn, rs, rt, rd);
        haz = v && ex_m.is_load == 1 && ex_m.dst != 0 && (ex_m.dst == rs || ex_m.dst == rt) && !fl;
        chk("hazard_stall", hazard_stall, haz);
        chk("id_is_jump", id_is_jump, d.jump_kind != 0 && !fl && !haz);
        chk("id_sel_j_jr", id_sel_j_jr, d.jump_kind == 2);
        chk("ex_alu_funct", ex_alu_funct, ex_m.funct);
        chk("ex_alu_src", ex_alu_src, ex_m.imm);
        chk("ex_is_load", ex_is_load, ex_m.is_load);
        chk("ex_fl_we", ex_fl_we, ex_m.fl_we);
        chk("fwd_a", fwd_a, src_of(ex_m.rs));
        chk("fwd_b", fwd_b, ex_m.imm == 1 ? 0 : src_of(ex_m.rt));
        chk("mem_we", mem_we, mem_m.mem_we);
        chk("mem_is_branch", mem_is_branch, mem_m.is_branch);
        chk("mem_sel_beq_bne", mem_sel_beq_bne, mem_m.beq_bne);
        chk("mem_sel_jt_jf", mem_sel_jt_jf, mem_m.jt_jf);
        chk("mem_sel_jflag", mem_sel_jflag_branch, mem_m.jflag);
        chk("wb_res_mux", wb_res_mux, wb_m.wb_mux);
        chk("wb_reg_we", wb_reg_we, wb_m.reg_we);
        chk("wb_dst", wb_dst, wb_m.dst);
        if (r) begin
            ex_m = bubble; mem_m = bubble; wb_m = bubble;
        end else if (!st) begin
            wb_m  = mem_m;
            mem_m = fl ? bubble : ex_m;
            ex_m  = (fl || haz) ? bubble : d;
        end
    endtask

    task automatic nops(input int n);
        logic h;
        for (int i = 0; i < n; i++) step(0, RTYPE, 0, 0, 0, 0, 0, 0, 0, h);
    endtask

    logic h;
    logic [5:0] fn_tab [7];

    initial begin
        bubble = '{default: 0};
        ex_m = bubble; mem_m = bubble; wb_m = bubble;
        fn_tab = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR, 6'h07};
        rst = 1; id_valid = 0; ext_stall = 0; flush = 0;
        id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        repeat (2) @(posedge clk);

        // Reset with a valid addi in ID, then let it through.
        step(1, ADDI, 0, 0, 3, 0, 0, 0, 1, h);
        step(1, ADDI, 0, 0, 3, 0, 0, 0, 1, h);
        step(1, ADDI, 0, 0, 3, 0, 0, 0, 0, h);
        nops(3);
        // Load-use: the add is held in ID for one cycle.
        step(1, LOAD, 0, 1, 2, 0, 0, 0, 0, h);
        step(1, RTYPE, F_ADD, 2, 5, 4, 0, 0, 0, h);
        chk("load_use_stall", h, 1'b1);
        step(1, RTYPE, F_ADD, 2, 5, 4, 0, 0, 0, h);
        chk("load_use_once", h, 1'b0);
        nops(3);
        // Back-to-back and one-apart dependencies.
        step(1, RTYPE, F_ADD, 2, 3, 1, 0, 0, 0, h);
        step(1, RTYPE, F_SUB, 1, 1, 6, 0, 0, 0, h);
        nops(3);
        step(1, RTYPE, F_ADD, 2, 3, 1, 0, 0, 0, h);
        nops(1);
        step(1, RTYPE, F_SUB, 1, 1, 6, 0, 0, 0, h);
        nops(3);
        // Branch resolves in MEM; the two younger instructions are discarded.
        step(1, BEQ, 0, 1, 2, 0, 0, 0, 0, h);
        step(1, STORE, 0, 1, 2, 0, 0, 0, 0, h);
        step(1, RTYPE, F_ADD, 1, 2, 7, 0, 1, 0, h);
        nops(3);
        // Freeze mid-stream.
        step(1, ADDI, 0, 0, 8, 0, 0, 0, 0, h);
        step(1, LOADLIT, 0, 0, 9, 0, 0, 0, 0, h);
        for (int i = 0; i < 3; i++) step(1, BNE, 0, 8, 9, 0, 1, 0, 0, h);
        step(1, BNE, 0, 8, 9, 0, 0, 0, 0, h);
        nops(3);
        // jal links r15; writes to r0 never forward or stall.
        step(1, JAL, 0, 0, 0, 0, 0, 0, 0, h);
        nops(3);
        step(1, LOAD, 0, 1, 0, 0, 0, 0, 0, h);
        step(1, RTYPE, F_ADD, 0, 0, 0, 0, 0, 0, h);
        chk("r0_no_hazard", h, 1'b0);
        step(1, RTYPE, F_SUB, 0, 0, 5, 0, 0, 0, h);
        nops(3);

        // Random streams over a small register set to provoke hazards and forwarding.
        begin
            logic       v, st, fl, r, hold;
            logic [5:0] opc, fn;
            int         rs, rt, rd;
            hold = 0; v = 0; opc = 0; fn = 0; rs = 0; rt = 0; rd = 0;
            for (int i = 0; i < 3000; i++) begin
                if (!hold) begin
                    v   = ($urandom_range(0, 7) != 0);
                    opc = 6'($urandom_range(0, 17));
                    fn  = fn_tab[$urandom_range(0, 6)];
                    rs  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                    rt  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                    rd  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                end
                r  = ($urandom_range(0, 99) == 0);
                st = ($urandom_range(0, 7) == 0);
                fl = ($urandom_range(0, 9) == 0);
                step(v, opc, fn, rs, rt, rd, st, fl, r, h);
                hold = !r && (st || h);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lapido_ctrl_pipeline.md
Name: lapido_ctrl_pipeline

Overview:
- Parametrised pipelined control unit for the LAPI DOpaCA LAMBA core. It decodes opcode/funct in ID and carries the control word through ID/EX, EX/MEM and MEM/WB stage registers.
- Adds three functions to decode alone:
  - load-use hazard detection with bubble insertion;
  - EX operand forwarding selects;
  - flush on branch resolution and global freeze.
- Sits beside the datapath. It drives every per-stage mux and enable; the datapath keeps only data registers.

Parameters:
- REG_ADDR_W, 4, register address width (16 registers).
- LINK_REG, 15, destination register written by jal.
- ZERO_REG_HARDWIRED, 1, when 1, r0 never triggers forwarding or hazards.
- HAZARD_EN, 1, when 0, hazard_stall is tied to 0 (software-scheduled loads).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  opcode in ID
- id_funct  in  6  R-type funct in ID
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  source/destination fields in ID
- ext_stall  in  1  freeze all stage registers (memory wait)
- flush  in  1  branch taken, resolved in MEM
- hazard_stall  out  1  hold PC and IF/ID; bubble into EX
- id_is_jump  out  1  unconditional jump in ID (j, jal, jr)
- id_sel_j_jr  out  1  jump target source, per `SEL_J/`SEL_JR
- ex_alu_funct  out  6  ALU operation
- ex_alu_src  out  1  `ALU_SRC_IMM/`ALU_SRC_REG
- ex_is_load, ex_fl_we  out  1 each  load in EX; flag-register write enable
- fwd_a, fwd_b  out  2 each  EX operand source: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data
- mem_we, mem_is_branch, mem_sel_beq_bne, mem_sel_jt_jf, mem_sel_jflag_branch  out  1 each  MEM-stage controls
- wb_res_mux  out  2  `WB_ALU/`WB_MEM/`WB_PC/`WB_IMM
- wb_reg_we  out  1  register-file write enable
- wb_dst  out  REG_ADDR_W  resolved write register

Behaviour:
- Decode (combinational, ID), encodings from lapido_defs.v:
  - store: mem_we.
  - load: reg_we, is_load, WB_MEM, dst=rt.
  - j: jump, SEL_J.
  - jal: jump, SEL_JR, reg_we, WB_PC, dst=LINK_REG.
  - beq/bne: branch, ALU_SRC_REG, FN_SUB, SEL_BRANCH, SEL_BEQ/SEL_BNE.
  - jt/jf: branch, SEL_JFLAG, SEL_JT/SEL_JF.
  - loadlit: reg_we, WB_IMM, dst=rt.
  - R-type with FN_JR: jump, SEL_JR, no writes.
  - Other R-type: alu_funct=funct, ALU_SRC_REG, dst=rd, reg_we, fl_we.
  - addi/andi/ori/slti/lcl/lch: immediate source, dst=rt, reg_we, fl_we. alu_funct is FN_ADD/FN_AND/FN_OR/FN_SLT/OP_LCL/OP_LCH respectively.
  - Unknown opcode: bubble.
- Bubble: all enables, is_load, is_branch and jump = 0; muxes = 0; alu_funct = 0; dst = 0. Every unassigned field of a valid instruction also takes its bubble value, so no latches are inferred.
- Reset: all three stage registers become bubbles. Every registered output reads 0 the cycle after rst is sampled. Reset mid-stream discards all in-flight instructions.
- Latency: an instruction decoded in cycle N drives ex_* in N+1, mem_* in N+2, wb_* in N+3.
- Update priority each edge: rst > ext_stall > flush > hazard_stall > normal advance.
  - ext_stall: all stage registers hold. Outputs stay stable; hazard_stall is still computed.
  - flush: ID/EX and EX/MEM load bubbles. MEM/WB advances normally, so the branch retires.
  - hazard_stall: ID/EX loads a bubble and EX/MEM, MEM/WB advance. The upstream holds ID, so it is re-presented the next cycle.
- hazard_stall = HAZARD_EN & id_valid & ex_is_load & (ex_dst==id_rs | ex_dst==id_rt) & !flush. When ZERO_REG_HARDWIRED=1, ex_dst==0 excludes the hazard. Exactly one bubble per load-use pair.
- id_is_jump is gated to 0 when id_valid=0, flush=1 or hazard_stall=1.
- fwd_a, with ex_rs stored in ID/EX:
  - 01 if mem_reg_we & !mem_is_load & mem_dst==ex_rs;
  - else 10 if wb_reg_we & wb_dst==ex_rs;
  - else 00.
  - fwd_b is identical with ex_rt. It is forced to 00 when ex_alu_src = immediate.
  - Register 0 is excluded when ZERO_REG_HARDWIRED=1.
  - The MEM match has priority over the WB match.
- Bubbles never match: their reg_we is 0.

Test Plan:
- rst=1 for 2 cycles with a valid addi in ID -> all ex/mem/wb outputs 0. After release, addi r3 appears at ex (alu_funct=FN_ADD) at N+1 and wb_reg_we=1, wb_dst=3 at N+3.
- load r2 then add r4,r2,r5 -> hazard_stall=1 for exactly one cycle with a bubble in EX. The add reaches EX with fwd_a=10.
- add r1,r2,r3 then sub r6,r1,r1 -> fwd_a=fwd_b=01. Insert one nop between them -> fwd_a=fwd_b=10.
- beq reaches MEM with flush=1 -> the two younger instructions never produce mem_we or wb_reg_we. The beq itself reaches WB with wb_reg_we=0.
- ext_stall=1 for 3 cycles mid-stream -> all outputs frozen; the sequence resumes unchanged.
- jal with LINK_REG=15 -> id_is_jump=1, wb_res_mux=WB_PC, wb_dst=15. Writing r0 with ZERO_REG_HARDWIRED=1 -> no forwarding or hazard triggered.
